hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Iterative multiply/divide unit owning the architectural HI/LO registers. Sits directly downstream of the ALU control decoder in the execute stage: consumes the 6-bit ALU control code with both register operands, runs mult/multu/div/divu over multiple cycles, and serves mfhi/mflo/mthi/mtlo. Exposes a stall to hold the pipeline while a HI/LO-dependent instruction meets an unfinished operation.

## Interface
- `XLEN`, 32: operand width; HI/LO are each XLEN bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: execute-stage instruction valid this cycle.
- `alu_ctrl` in 6: decoded ALU control code (16 mfhi, 17 mthi, 18 mflo, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu; all other codes ignored).
- `rs_val` in XLEN: operand A / dividend / mthi-mtlo source.
- `rt_val` in XLEN: operand B / divisor.
- `stall` out 1: combinational; high when op_valid, code is a HI/LO code (16–19, 24–27), and busy.
- `busy` out 1: registered; high while an operation is in flight.
- `done` out 1: registered one-cycle pulse when HI/LO receive a mult/div result.
- `hilo_rdata` out XLEN: combinational; LO when alu_ctrl==18, else HI.
- `hi`, `lo` out XLEN: architectural registers.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: op_valid & code 24–27 & !stall → latch operands, magnitudes (signed ops only), result-sign flags, clear 6-bit iteration counter, go RUN.
- IDLE: op_valid & code 17/19 → HI/LO := rs_val at that edge. Codes 16/18 read only.
- RUN: one shift-add (mult) or restoring-subtract (div) step per cycle; counter 0..XLEN-1; at count XLEN-1 go FIX.
- FIX: sign fixup; write HI/LO; pulse done; go IDLE.
- Mult: {HI,LO} = 64-bit product; signed → negate 64-bit magnitude product if operand signs differ.
- Div: LO = quotient, HI = remainder; signed → quotient negated if signs differ, remainder takes dividend sign.
- Divide by zero (divisor==0): LO = all ones, HI = rs_val; still full latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Codes outside 16–19, 24–27: no effect on any state.
- While busy, all HI/LO codes stall; upstream holds op_valid/alu_ctrl/operands until stall falls.

## Timing
- Reset: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0; stall deasserts with busy.
- Accept at edge E0; RUN on E1..E32; FIX at E33. busy high for 33 cycles (after E0 through E33). done and new HI/LO visible the cycle after E33.
- Instruction pending during done cycle: busy=0, so accepted/served that cycle (back-to-back start allowed).
- mthi/mtlo: HI/LO update at the accepting edge; mfhi/mflo see new value the next cycle.
- rst mid-RUN/FIX: aborts, no HI/LO write, no done pulse, all reset values next cycle.

## Configuration
- `HILO_FAST_MULT_EN` defined: codes 24/25 computed by single-cycle `*` multiplier; HI/LO written at the accepting edge; busy stays 0; done pulses the following cycle. Divide unchanged (33 cycles).
- Undefined: multiply uses iterative 33-cycle path as above.

## Structure
- Shared package `alu_ctrl_pkg`: localparams for all ALU control codes (16–19, 24–27 used here), FSM state typedef, XLEN default.
- One sub-module `muldiv_iter_core`: shift registers, adder/subtractor, counter for one iteration per cycle; the top holds FSM, sign handling, HI/LO, stall logic.

## Test plan
- mult rs=0xFFFFFFFF, rt=0x00000002 → after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 → LO=14, HI=2.
- divu rs=0x1234, rt=0 → LO=0xFFFFFFFF, HI=0x1234; div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mult started, mflo presented on next cycle → stall held 33 cycles, hilo_rdata equals new LO in done cycle with stall low.
- mthi 0xA5A5A5A5 then mfhi → hilo_rdata=0xA5A5A5A5; rst asserted at RUN count 10 → hi=lo=0, busy=0, no done.
- With HILO_FAST_MULT_EN: mult 3×-4 → HI=0xFFFFFFFF, LO=0xFFFFFFF4 next cycle, busy never high.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, muldiv FSM states and default datapath width.
package alu_ctrl_pkg;
   localparam int XLEN_DEF = 32;
   localparam logic [5:0] ALU_MFHI  = 6'd16;
   localparam logic [5:0] ALU_MTHI  = 6'd17;
   localparam logic [5:0] ALU_MFLO  = 6'd18;
   localparam logic [5:0] ALU_MTLO  = 6'd19;
   localparam logic [5:0] ALU_MULT  = 6'd24;
   localparam logic [5:0] ALU_MULTU = 6'd25;
   localparam logic [5:0] ALU_DIV   = 6'd26;
   localparam logic [5:0] ALU_DIVU  = 6'd27;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} muldiv_state_e;
   // 16-19 and 24-27 are the only codes that touch HI/LO
   function automatic logic is_hilo_code(input logic [5:0] c);
      return (c[5:2] == 4'b0100) | (c[5:2] == 4'b0110);
   endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned shift-add multiply / restoring divide, one bit per step.
module muldiv_iter_core #(parameter int XLEN = 32) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic            div_mode,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            last,
   output logic [XLEN-1:0] acc,
   output logic [XLEN-1:0] low
);
   logic [XLEN-1:0] acc_q, acc_d, sh_q, sh_d, b_q, b_d;
   logic [5:0] cnt_q, cnt_d;
   logic div_q, div_d, ge;
   logic [XLEN:0] mul_sum, rem_sh;
   logic [XLEN+1:0] diff;
   always_comb begin
      mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
      rem_sh = {acc_q, sh_q[XLEN-1]};
      diff = {1'b0, rem_sh} - {2'b0, b_q};
      ge = !diff[XLEN+1];
      acc_d = start ? '0 : !step ? acc_q : div_q ? (ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]) : mul_sum[XLEN:1];
      sh_d = start ? a : !step ? sh_q : div_q ? {sh_q[XLEN-2:0], ge} : {mul_sum[0], sh_q[XLEN-1:1]};
      b_d = start ? b : b_q;
      div_d = start ? div_mode : div_q;
      cnt_d = start ? '0 : step ? cnt_q + 6'd1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         sh_q <= '0;
         b_q <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         sh_q <= sh_d;
         b_q <= b_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end
   assign last = cnt_q == 6'(XLEN-1);
   assign acc = acc_q;
   assign low = sh_q;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO registers with iterative mult/div, mfhi/mflo/mthi/mtlo and pipeline stall.
// Define HILO_FAST_MULT_EN to compute mult/multu in a single cycle with a combinational multiplier.
module hilo_muldiv_unit import alu_ctrl_pkg::*; #(parameter int XLEN = XLEN_DEF) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic [5:0]      alu_ctrl,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hilo_rdata,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   muldiv_state_e state_q, state_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, rs_q, rs_d, a_mag, b_mag, core_acc, core_low;
   logic neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, dz_q, dz_d, done_q, done_d;
   logic is_mul, is_div, sgn, iter_op, idle_v, start, fix, last;
   logic [2*XLEN-1:0] prod;
   assign is_mul = alu_ctrl == ALU_MULT || alu_ctrl == ALU_MULTU;
   assign is_div = alu_ctrl == ALU_DIV || alu_ctrl == ALU_DIVU;
   assign sgn = alu_ctrl == ALU_MULT || alu_ctrl == ALU_DIV;
`ifdef HILO_FAST_MULT_EN
   logic [2*XLEN-1:0] fast_p;
   assign fast_p = {{XLEN{sgn & rs_val[XLEN-1]}}, rs_val} * {{XLEN{sgn & rt_val[XLEN-1]}}, rt_val};
   assign iter_op = is_div;
`else
   assign iter_op = is_mul | is_div;
`endif
   assign busy = state_q != S_IDLE;
   assign stall = op_valid & is_hilo_code(alu_ctrl) & busy;
   assign idle_v = state_q == S_IDLE & op_valid;
   assign start = idle_v & iter_op & !stall;
   assign fix = state_q == S_FIX;
   assign a_mag = sgn & rs_val[XLEN-1] ? -rs_val : rs_val;
   assign b_mag = sgn & rt_val[XLEN-1] ? -rt_val : rt_val;
   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk(clk), .rst(rst), .start(start), .step(state_q == S_RUN), .div_mode(is_div),
      .a(a_mag), .b(b_mag), .last(last), .acc(core_acc), .low(core_low)
   );
   always_comb begin
      state_d = state_q == S_IDLE ? (start ? S_RUN : S_IDLE) : state_q == S_RUN ? (last ? S_FIX : S_RUN) : S_IDLE;
      rs_d = start ? rs_val : rs_q;
      neg_d = start ? sgn & (rs_val[XLEN-1] ^ rt_val[XLEN-1]) : neg_q;
      rneg_d = start ? sgn & rs_val[XLEN-1] : rneg_q;
      div_d = start ? is_div : div_q;
      dz_d = start ? rt_val == '0 : dz_q;
      prod = neg_q ? -{core_acc, core_low} : {core_acc, core_low};
      // divide by zero bypasses the sign fixup: quotient all ones, remainder is the raw dividend
      hi_d = fix ? (div_q ? (dz_q ? rs_q : rneg_q ? -core_acc : core_acc) : prod[2*XLEN-1:XLEN])
           : idle_v && alu_ctrl == ALU_MTHI ? rs_val : hi_q;
      lo_d = fix ? (div_q ? (dz_q ? '1 : neg_q ? -core_low : core_low) : prod[XLEN-1:0])
           : idle_v && alu_ctrl == ALU_MTLO ? rs_val : lo_q;
      done_d = fix;
`ifdef HILO_FAST_MULT_EN
      if (idle_v & is_mul) begin
         hi_d = fast_p[2*XLEN-1:XLEN];
         lo_d = fast_p[XLEN-1:0];
         done_d = 1'b1;
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hi_q <= '0;
         lo_q <= '0;
         rs_q <= '0;
         neg_q <= 1'b0;
         rneg_q <= 1'b0;
         div_q <= 1'b0;
         dz_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         rs_q <= rs_d;
         neg_q <= neg_d;
         rneg_q <= rneg_d;
         div_q <= div_d;
         dz_q <= dz_d;
         done_q <= done_d;
      end
   end
   assign done = done_q;
   assign hi = hi_q;
   assign lo = lo_q;
   assign hilo_rdata = alu_ctrl == ALU_MFLO ? lo_q : hi_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed checks of HI/LO moves, mult/div results, latency, stall and reset abort.
module tb_hilo_muldiv_unit;
   logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
   logic [5:0] alu_ctrl = 6'd0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic stall, busy, done;
   logic [31:0] hilo_rdata, hi, lo;
   int checks = 0, errors = 0;
   hilo_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .alu_ctrl(alu_ctrl), .rs_val(rs_val), .rt_val(rt_val),
      .stall(stall), .busy(busy), .done(done), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   function automatic int lat(input logic [5:0] c);
`ifdef HILO_FAST_MULT_EN
      return (c == 6'd24 || c == 6'd25) ? 0 : 33;
`else
      return 33;
`endif
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic do_op(input string tag, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      int n;
      op_valid = 1'b1; alu_ctrl = c; rs_val = a; rt_val = b;
      @(negedge clk);
      op_valid = 1'b0; alu_ctrl = 6'd0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'(lat(c)));
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
   endtask
   initial begin
      int n;
      repeat (2) @(negedge clk);
      op_valid = 1'b1; alu_ctrl = 6'd16;
      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      op_valid = 1'b1; alu_ctrl = 6'd17; rs_val = 32'hA5A5A5A5;
      @(negedge clk);
      alu_ctrl = 6'd16; rs_val = 32'h0;
      #1;
      chk("mthi_rdata", hilo_rdata, 32'hA5A5A5A5);
      chk("mthi_lo_kept", lo, 32'h0);
      alu_ctrl = 6'd19; rs_val = 32'h5A5A0001;
      @(negedge clk);
      alu_ctrl = 6'd18;
      #1;
      chk("mtlo_rdata", hilo_rdata, 32'h5A5A0001);
      chk("mtlo_hi_kept", hi, 32'hA5A5A5A5);
      alu_ctrl = 6'd20; rs_val = 32'hDEADBEEF;
      @(negedge clk);
      op_valid = 1'b0;
      chk("ignored_hi", hi, 32'hA5A5A5A5);
      chk("ignored_lo", lo, 32'h5A5A0001);
      chk("ignored_busy", {31'b0, busy}, 32'd0);
      do_op("mult", 6'd24, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
      do_op("multu", 6'd25, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
      do_op("mult_3x-4", 6'd24, 32'h3, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4);
      do_op("div_-7/2", 6'd26, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      do_op("divu_100/7", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
      do_op("divu_by0", 6'd27, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
      do_op("div_neg_by0", 6'd26, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF);
      do_op("div_ovf", 6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      op_valid = 1'b1; alu_ctrl = 6'd24; rs_val = 32'd5; rt_val = 32'd6;
      @(negedge clk);
      alu_ctrl = 6'd18; rs_val = 32'h0; rt_val = 32'h0;
      n = 0;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("mflo_stall_cycles", 32'(n), 32'(lat(6'd24)));
      chk("mflo_done", {31'b0, done}, 32'd1);
      chk("mflo_rdata", hilo_rdata, 32'd30);
      alu_ctrl = 6'd16;
      #1;
      chk("mfhi_rdata", hilo_rdata, 32'd0);
      op_valid = 1'b0;
      @(negedge clk);
      do_op("b2b_divu", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
      op_valid = 1'b1; alu_ctrl = 6'd19; rs_val = 32'h77;
      @(negedge clk);
      op_valid = 1'b0; alu_ctrl = 6'd0;
      chk("b2b_mtlo", lo, 32'h77);
      chk("b2b_hi", hi, 32'd2);
      op_valid = 1'b1; alu_ctrl = 6'd27; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      op_valid = 1'b0; alu_ctrl = 6'd0;
      repeat (10) @(negedge clk);
      chk("abort_busy_before", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      n = 0;
      repeat (40) begin
         if (done) n++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(n), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
